// File: rtl/backprop_pkg.sv
// Shared types and arithmetic helpers for the back-propagation gatherer.
// Holds the controller state encoding, default geometry and the saturating adder.
package backprop_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int NUM_IN_DEF = 32;
    localparam int WIDTH_DEF  = 32;
    localparam int ACC_W_DEF  = 64;

    // Widest accumulator the adder can clamp; callers sign-extend into this width.
    localparam int MAX_ACC_W  = 128;

    typedef struct packed {
        logic [MAX_ACC_W-1:0] sum;
        logic                 ovf;
    } sat_res_t;

    // Adds two sign-extended operands and clamps the result to a signed acc_w-bit range.
    function automatic sat_res_t sat_add(
        input logic signed [MAX_ACC_W-1:0] acc,
        input logic signed [MAX_ACC_W-1:0] val,
        input int                          acc_w
    );
        logic signed [MAX_ACC_W:0] s;
        logic signed [MAX_ACC_W:0] one;
        logic signed [MAX_ACC_W:0] max_v;
        logic signed [MAX_ACC_W:0] min_v;
        sat_res_t                  r;
        one    = '0;
        one[0] = 1'b1;
        s      = {acc[MAX_ACC_W-1], acc} + {val[MAX_ACC_W-1], val};
        max_v  = (one << (acc_w - 1)) - one;
        min_v  = ~max_v;
        if (s > max_v) begin
            r.sum = max_v[MAX_ACC_W-1:0];
            r.ovf = 1'b1;
        end else if (s < min_v) begin
            r.sum = min_v[MAX_ACC_W-1:0];
            r.ovf = 1'b1;
        end else begin
            r.sum = s[MAX_ACC_W-1:0];
            r.ovf = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/backprop_gatherer_priority_next_index.sv
// Combinational lowest-set-bit finder used to walk the enable mask.
// Returns the index of the lowest set bit and whether any bit is set.
module priority_next_index
    import backprop_pkg::*;
#(
    parameter int N     = NUM_IN_DEF,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     mask,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            index = mask[i] ? IDX_W'(i) : index;
        end
        any = |mask;
    end

endmodule

// File: rtl/backprop_gatherer.sv
// Sums per-neuron back vectors into saturating accumulators, then streams the
// enabled sums out one index at a time as backprop-start values for the layer above.
module backprop_gatherer
    import backprop_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN-1:0]       enabled,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [NUM_IN*WIDTH-1:0] back,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_last,
    output logic                    done,
    output logic                    sat_flag
);

    state_t                  state_r;
    logic signed [ACC_W-1:0] acc_r [NUM_IN];
    logic [NUM_IN-1:0]       mask_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic [ACC_W-1:0]        out_data_r;
    logic [IDX_W-1:0]        out_index_r;
    logic                    out_last_r;
    logic                    done_r;
    logic                    sat_r;

    logic [ACC_W-1:0]        acc_sum_s [NUM_IN];
    logic                    ovf_any_s;
    logic [NUM_IN-1:0]       cur_bit_s;
    logic [NUM_IN-1:0]       mask_rem_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    any_s;
    logic                    last_s;

    // Saturating sum of every accumulator with its incoming back element.
    always_comb begin : sat_calc
        sat_res_t res;
        ovf_any_s = 1'b0;
        res       = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            res = sat_add({{(MAX_ACC_W-ACC_W){acc_r[i][ACC_W-1]}}, acc_r[i]},
                          {{(MAX_ACC_W-WIDTH){back[i*WIDTH+WIDTH-1]}}, back[i*WIDTH +: WIDTH]},
                          ACC_W);
            acc_sum_s[i] = res.sum[ACC_W-1:0];
            ovf_any_s    = ovf_any_s | res.ovf;
        end
    end

    // In DRAIN the bit being presented is excluded, so the finder yields the next index.
    always_comb begin
        cur_bit_s              = '0;
        cur_bit_s[out_index_r] = 1'b1;
        if (state_r == DRAIN) begin
            mask_rem_s = mask_r & ~cur_bit_s;
        end else begin
            mask_rem_s = mask_r;
        end
        last_s = ((mask_rem_s & (mask_rem_s - NUM_IN'(1))) == '0);
    end

    priority_next_index #(
        .N     (NUM_IN),
        .IDX_W (IDX_W)
    ) u_find (
        .mask  (mask_rem_s),
        .index (idx_s),
        .any   (any_s)
    );

    // Batch controller: accumulate, locate the first enabled index, then drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            mask_r      <= '0;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_index_r <= '0;
            out_last_r  <= 1'b0;
            done_r      <= 1'b0;
            sat_r       <= 1'b0;
            for (int i = 0; i < NUM_IN; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ACCUM: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        for (int i = 0; i < NUM_IN; i++) begin
                            acc_r[i] <= acc_sum_s[i];
                        end
                        sat_r <= sat_r | ovf_any_s;
                        if (in_last) begin
                            mask_r     <= enabled;
                            in_ready_r <= 1'b0;
                            state_r    <= SCAN;
                        end else begin
                            state_r <= ACCUM;
                        end
                    end else begin
                        state_r <= ACCUM;
                    end
                end
                SCAN: begin
                    if (any_s) begin
                        out_index_r <= idx_s;
                        out_data_r  <= acc_r[idx_s];
                        out_last_r  <= last_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DRAIN;
                    end else begin
                        done_r     <= 1'b1;
                        sat_r      <= 1'b0;
                        in_ready_r <= 1'b1;
                        state_r    <= ACCUM;
                        for (int i = 0; i < NUM_IN; i++) begin
                            acc_r[i] <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_r && out_ready) begin
                        if (out_last_r) begin
                            out_valid_r <= 1'b0;
                            out_last_r  <= 1'b0;
                            mask_r      <= '0;
                            done_r      <= 1'b1;
                            sat_r       <= 1'b0;
                            in_ready_r  <= 1'b1;
                            state_r     <= ACCUM;
                            for (int i = 0; i < NUM_IN; i++) begin
                                acc_r[i] <= '0;
                            end
                        end else begin
                            mask_r      <= mask_rem_s;
                            out_index_r <= idx_s;
                            out_data_r  <= acc_r[idx_s];
                            out_last_r  <= last_s;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_index = out_index_r;
    assign out_last  = out_last_r;
    assign done      = done_r;
    assign sat_flag  = sat_r;

endmodule

// File: tb/tb_backprop_gatherer.sv
// Scoreboard bench for backprop_gatherer: default instance plus a narrow-accumulator
// instance for the saturation scenario.
module tb_backprop_gatherer;

    localparam int N = 32;
    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    enabled;
    logic            in_valid;
    logic            in_valid_s;
    logic            in_last;
    logic [N*W-1:0]  back;
    logic            out_ready;

    logic            in_ready, out_valid, out_last, done, sat_flag;
    logic [63:0]     out_data;
    logic [4:0]      out_index;

    logic            s_in_ready, s_out_valid, s_out_last, s_done, s_sat_flag;
    logic [33:0]     s_out_data;
    logic [4:0]      s_out_index;

    typedef struct {
        int     idx;
        longint data;
        bit     last;
    } exp_t;

    exp_t   exp_q[$];
    longint model_acc [N];
    int     checks = 0;
    int     errors = 0;

    always #5 clk = ~clk;

    backprop_gatherer dut (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .back(back), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
        .out_last(out_last), .done(done), .sat_flag(sat_flag)
    );

    backprop_gatherer #(.ACC_W(34)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enabled(enabled), .in_valid(in_valid_s),
        .in_ready(s_in_ready), .in_last(in_last), .back(back), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_data(s_out_data), .out_index(s_out_index),
        .out_last(s_out_last), .done(s_done), .sat_flag(s_sat_flag)
    );

    function automatic logic [N*W-1:0] fill(input logic [W-1:0] x);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = x;
        return v;
    endfunction

    function automatic logic [N*W-1:0] ramp();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(i);
        return v;
    endfunction

    // Drives one beat into the default instance and updates the reference sums.
    task automatic send_vec(input logic [N*W-1:0] v, input logic last,
                            input logic [N-1:0] en, input bit wait_edge);
        if (wait_edge) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_in_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        back     = v;
        in_last  = last;
        enabled  = en;
        for (int i = 0; i < N; i++) model_acc[i] += $signed(v[i*W +: W]);
        if (last) begin
            for (int i = 0; i < N; i++) begin
                if (en[i]) exp_q.push_back('{i, model_acc[i], ((en >> (i + 1)) == '0)});
            end
            for (int i = 0; i < N; i++) model_acc[i] = 0;
        end
    endtask

    // Consumes the drain of the default instance against the scoreboard; mode 1 applies backpressure.
    task automatic drain(input int mode);
        bit          expect_done = 0;
        bit          finished    = 0;
        bit          first       = 1;
        bit          prev_hold   = 0;
        logic [63:0] prev_data   = '0;
        logic [4:0]  prev_idx    = '0;
        exp_t        e;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL scan_cycle: out_valid=%b in_ready=%b want 0 0", out_valid, in_ready);
        end
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            if (first) begin
                first = 0;
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_valid_latency: out_valid=%b want 1", out_valid);
                end
            end
            if (expect_done) begin
                finished = 1;
                checks++;
                if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL done_pulse: done=%b out_valid=%b in_ready=%b want 1 0 1",
                             done, out_valid, in_ready);
                end
            end else begin
                out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
                if (out_valid === 1'b1) begin
                    checks++;
                    if (done !== 1'b0 || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL drain_ctrl: done=%b in_ready=%b want 0 0", done, in_ready);
                    end
                    if (prev_hold) begin
                        checks++;
                        if (out_data !== prev_data || out_index !== prev_idx) begin
                            errors++;
                            $display("FAIL hold: data=%h idx=%0d want %h %0d",
                                     out_data, out_index, prev_data, prev_idx);
                        end
                    end
                    if (exp_q.size() == 0) begin
                        errors++;
                        finished = 1;
                        $display("FAIL extra_output: idx=%0d data=%h", out_index, out_data);
                    end else begin
                        e = exp_q[0];
                        checks++;
                        if (out_index !== 5'(e.idx) || out_data !== e.data || out_last !== e.last) begin
                            errors++;
                            $display("FAIL out_beat: idx=%0d data=%h last=%b want %0d %h %b",
                                     out_index, out_data, out_last, e.idx, e.data, e.last);
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            prev_hold   = 0;
                            expect_done = e.last;
                        end else begin
                            prev_hold = 1;
                            prev_data = out_data;
                            prev_idx  = out_index;
                        end
                    end
                end
            end
        end
        checks++;
        if (!finished || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_end: finished=%b pending=%0d want 1 0", finished, exp_q.size());
        end
        exp_q.delete();
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'd0 || out_index !== 5'd0 ||
            out_last !== 1'b0 || done !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b data=%h idx=%0d last=%b done=%b sat=%b want all 0",
                     in_ready, out_valid, out_data, out_index, out_last, done, sat_flag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_sum();
        send_vec(fill(32'd1), 1'b0, '1, 1'b1);
        send_vec(fill(32'hFFFF_FFFD), 1'b0, '1, 1'b1);
        send_vec(fill(32'd1), 1'b1, '1, 1'b1);
        drain(0);
    endtask

    task automatic test_sparse();
        send_vec(ramp(), 1'b1, 32'h0000_0005, 1'b1);
        drain(0);
    endtask

    task automatic test_backpressure();
        send_vec(fill(32'd1), 1'b0, '1, 1'b1);
        send_vec(fill(32'hFFFF_FFFD), 1'b0, '1, 1'b1);
        send_vec(fill(32'd1), 1'b1, '1, 1'b1);
        drain(1);
    endtask

    task automatic test_saturation();
        int  count = 0;
        bit  seen_done = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (s_in_ready !== 1'b1) begin
                errors++;
                $display("FAIL sat_in_ready: got %b want 1", s_in_ready);
            end
            in_valid_s = 1'b1;
            back       = fill(32'h7FFF_FFFF);
            in_last    = (k == 4);
            enabled    = '1;
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
            @(negedge clk);
            in_valid_s = 1'b0;
            in_last    = 1'b0;
            if (s_out_valid === 1'b1) begin
                checks++;
                if (s_out_data !== 34'h1_FFFF_FFFF || s_out_index !== 5'(count) || s_sat_flag !== 1'b1) begin
                    errors++;
                    $display("FAIL sat_out: data=%h idx=%0d sat=%b want 1ffffffff %0d 1",
                             s_out_data, s_out_index, s_sat_flag, count);
                end
                count++;
            end
            if (s_done === 1'b1) seen_done = 1;
        end
        checks++;
        if (!seen_done || count != 32) begin
            errors++;
            $display("FAIL sat_count: done=%b outputs=%0d want 1 32", seen_done, count);
        end
        @(negedge clk);
        checks++;
        if (s_sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: sat_flag=%b want 0", s_sat_flag);
        end
    endtask

    task automatic test_zero_mask_and_reset();
        send_vec(fill(32'd9), 1'b1, '0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (done !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_scan: done=%b out_valid=%b want 0 0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done=%b out_valid=%b want 1 0", done, out_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_after: done=%b in_ready=%b want 0 1", done, in_ready);
        end
        send_vec(fill(32'd5), 1'b1, '1, 1'b1);
        exp_q.delete();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain: out_valid=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || out_data !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: vld=%b rdy=%b done=%b data=%h want 0 0 0 0",
                     out_valid, in_ready, done, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        send_vec(ramp(), 1'b1, '1, 1'b0);
        drain(0);
    endtask

    task automatic test_back_to_back();
        send_vec(fill(32'd7), 1'b0, '1, 1'b1);
        send_vec(fill(32'd2), 1'b1, 32'hF0F0_F0F0, 1'b1);
        drain(0);
        send_vec(fill(32'hFFFF_FFFC), 1'b0, '1, 1'b0);
        send_vec(fill(32'd10), 1'b1, 32'h8000_0001, 1'b1);
        drain(0);
    endtask

    initial begin
        rst_n      = 1'b0;
        enabled    = '0;
        in_valid   = 1'b0;
        in_valid_s = 1'b0;
        in_last    = 1'b0;
        back       = '0;
        out_ready  = 1'b1;
        for (int i = 0; i < N; i++) model_acc[i] = 0;
        test_reset();
        test_sum();
        test_sparse();
        test_backpressure();
        test_saturation();
        test_zero_mask_and_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
